// File: rtl/reg_file_rename.sv
// ============================================================================
// Module      : reg_file_rename
// Description : Architectural register file with per-register ROB rename tags.
//               Optional macro REGFILE_COMMIT_BYPASS_EN forwards a same-cycle
//               commit onto the decode read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file_rename #(
   parameter int REG_NUM   = 32,
   parameter int REG_IDX_W = 5,
   parameter int DATA_W    = 32,
   parameter int ROB_TAG_W = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rdy,
   input  logic [REG_IDX_W-1:0] in_decode_rs1,
   output logic [DATA_W-1:0]    out_decode_value1,
   output logic [ROB_TAG_W-1:0] out_decode_tag1,
   input  logic [REG_IDX_W-1:0] in_decode_rs2,
   output logic [DATA_W-1:0]    out_decode_value2,
   output logic [ROB_TAG_W-1:0] out_decode_tag2,
   input  logic                 in_decode_rename_ce,
   input  logic [REG_IDX_W-1:0] in_decode_rd,
   input  logic [ROB_TAG_W-1:0] in_decode_rob_tag,
   input  logic [REG_IDX_W-1:0] in_rob_commit_index,
   input  logic [ROB_TAG_W-1:0] in_rob_commit_tag,
   input  logic [DATA_W-1:0]    in_rob_commit_value,
   input  logic                 in_misbranch
);

   logic [DATA_W-1:0]    r_value [REG_NUM];
   logic [ROB_TAG_W-1:0] r_tag   [REG_NUM];

   logic w_commit_en;
   logic w_rename_en;

   assign w_commit_en = (in_rob_commit_index != '0);
   assign w_rename_en = in_decode_rename_ce && (in_decode_rd != '0) && !in_misbranch;

   // Later non-blocking writes override earlier ones, giving the tag priority
   // misbranch clear > rename > commit release.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            r_value[i] <= '0;
            r_tag[i]   <= '0;
         end
      end else if (rdy) begin
         if (w_commit_en) begin
            r_value[in_rob_commit_index] <= in_rob_commit_value;
            if (r_tag[in_rob_commit_index] == in_rob_commit_tag)
               r_tag[in_rob_commit_index] <= '0;
         end
         if (w_rename_en)
            r_tag[in_decode_rd] <= in_decode_rob_tag;
         if (in_misbranch) begin
            for (int i = 0; i < REG_NUM; i++)
               r_tag[i] <= '0;
         end
      end
   end

   function automatic logic [ROB_TAG_W+DATA_W-1:0] f_read(input logic [REG_IDX_W-1:0] rs);
      logic [DATA_W-1:0]    v;
      logic [ROB_TAG_W-1:0] t;
      v = '0;
      t = '0;
      if (rs != '0) begin
         v = r_value[rs];
         t = r_tag[rs];
`ifdef REGFILE_COMMIT_BYPASS_EN
         if (rdy && (rs == in_rob_commit_index)) begin
            v = in_rob_commit_value;
            if (r_tag[rs] == in_rob_commit_tag)
               t = '0;
         end
`endif
      end
      return {t, v};
   endfunction

   assign {out_decode_tag1, out_decode_value1} = f_read(in_decode_rs1);
   assign {out_decode_tag2, out_decode_value2} = f_read(in_decode_rs2);

endmodule

`default_nettype wire

// File: tb/tb_reg_file_rename.sv
// ============================================================================
// Module      : tb_reg_file_rename
// Description : Scoreboard bench for reg_file_rename (directed + random).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_reg_file_rename;

   localparam int REG_NUM   = 32;
   localparam int REG_IDX_W = 5;
   localparam int DATA_W    = 32;
   localparam int ROB_TAG_W = 4;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 rdy = 1'b1;
   logic [REG_IDX_W-1:0] in_decode_rs1 = '0;
   logic [DATA_W-1:0]    out_decode_value1;
   logic [ROB_TAG_W-1:0] out_decode_tag1;
   logic [REG_IDX_W-1:0] in_decode_rs2 = '0;
   logic [DATA_W-1:0]    out_decode_value2;
   logic [ROB_TAG_W-1:0] out_decode_tag2;
   logic                 in_decode_rename_ce = 1'b0;
   logic [REG_IDX_W-1:0] in_decode_rd = '0;
   logic [ROB_TAG_W-1:0] in_decode_rob_tag = '0;
   logic [REG_IDX_W-1:0] in_rob_commit_index = '0;
   logic [ROB_TAG_W-1:0] in_rob_commit_tag = '0;
   logic [DATA_W-1:0]    in_rob_commit_value = '0;
   logic                 in_misbranch = 1'b0;

   reg_file_rename #(
      .REG_NUM(REG_NUM), .REG_IDX_W(REG_IDX_W), .DATA_W(DATA_W), .ROB_TAG_W(ROB_TAG_W)
   ) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .in_decode_rs1(in_decode_rs1), .out_decode_value1(out_decode_value1),
      .out_decode_tag1(out_decode_tag1),
      .in_decode_rs2(in_decode_rs2), .out_decode_value2(out_decode_value2),
      .out_decode_tag2(out_decode_tag2),
      .in_decode_rename_ce(in_decode_rename_ce), .in_decode_rd(in_decode_rd),
      .in_decode_rob_tag(in_decode_rob_tag),
      .in_rob_commit_index(in_rob_commit_index), .in_rob_commit_tag(in_rob_commit_tag),
      .in_rob_commit_value(in_rob_commit_value), .in_misbranch(in_misbranch)
   );

   always #5 clk = ~clk;

   typedef struct {
      int                   step;
      logic [DATA_W-1:0]    v1;
      logic [ROB_TAG_W-1:0] t1;
      logic [DATA_W-1:0]    v2;
      logic [ROB_TAG_W-1:0] t2;
   } exp_t;

   exp_t q[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   step_cnt = 0;

   // Reference model: architectural state as plain arrays
   logic [DATA_W-1:0]    m_val [REG_NUM];
   logic [ROB_TAG_W-1:0] m_tag [REG_NUM];

   function automatic void model_read(input logic [REG_IDX_W-1:0] rs,
                                      input logic rdy_i,
                                      input logic [REG_IDX_W-1:0] ci,
                                      input logic [ROB_TAG_W-1:0] ct,
                                      input logic [DATA_W-1:0] cv,
                                      output logic [DATA_W-1:0] v,
                                      output logic [ROB_TAG_W-1:0] t);
      int r;
      r = int'(rs);
      v = (r == 0) ? '0 : m_val[r];
      t = (r == 0) ? '0 : m_tag[r];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (r != 0 && rdy_i && rs == ci) begin
         v = cv;
         if (m_tag[r] == ct) t = '0;
      end
`endif
   endfunction

   // One cycle: drive inputs just after an edge, queue expected reads, then
   // advance the model to the state the next edge should produce.
   task automatic cyc(input logic r, input logic rdy_i,
                      input logic [REG_IDX_W-1:0] rs1, input logic [REG_IDX_W-1:0] rs2,
                      input logic ce, input logic [REG_IDX_W-1:0] rd,
                      input logic [ROB_TAG_W-1:0] rt,
                      input logic [REG_IDX_W-1:0] ci, input logic [ROB_TAG_W-1:0] ct,
                      input logic [DATA_W-1:0] cv, input logic mis);
      exp_t e;
      logic [ROB_TAG_W-1:0] old_tag [REG_NUM];
      @(posedge clk);
      #1;
      rst = r; rdy = rdy_i; in_decode_rs1 = rs1; in_decode_rs2 = rs2;
      in_decode_rename_ce = ce; in_decode_rd = rd; in_decode_rob_tag = rt;
      in_rob_commit_index = ci; in_rob_commit_tag = ct; in_rob_commit_value = cv;
      in_misbranch = mis;
      step_cnt++;
      if (!r) begin
         e.step = step_cnt;
         model_read(rs1, rdy_i, ci, ct, cv, e.v1, e.t1);
         model_read(rs2, rdy_i, ci, ct, cv, e.v2, e.t2);
         q.push_back(e);
      end
      if (r) begin
         for (int i = 0; i < REG_NUM; i++) begin m_val[i] = '0; m_tag[i] = '0; end
      end else if (rdy_i) begin
         for (int i = 0; i < REG_NUM; i++) old_tag[i] = m_tag[i];
         for (int i = 1; i < REG_NUM; i++) begin
            if (mis)
               m_tag[i] = '0;
            else if (ce && rd == i[REG_IDX_W-1:0])
               m_tag[i] = rt;
            else if (ci == i[REG_IDX_W-1:0] && old_tag[i] == ct)
               m_tag[i] = '0;
            if (ci == i[REG_IDX_W-1:0])
               m_val[i] = cv;
         end
      end
   endtask

   task automatic chk(input string nm, input int step, input logic [DATA_W-1:0] act,
                      input logic [DATA_W-1:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fails++;
         $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, step, act, expv);
      end
   endtask

   // Monitor: read ports are valid every cycle, sampled mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("value1", e.step, out_decode_value1, e.v1);
            chk("tag1",   e.step, DATA_W'(out_decode_tag1), DATA_W'(e.t1));
            chk("value2", e.step, out_decode_value2, e.v2);
            chk("tag2",   e.step, DATA_W'(out_decode_tag2), DATA_W'(e.t2));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [REG_IDX_W-1:0] ci, rd;
      logic [ROB_TAG_W-1:0] ct;
      for (int i = 0; i < REG_NUM; i++) begin m_val[i] = '0; m_tag[i] = '0; end
      repeat (3) cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // reset state
      cyc(0, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
      // rename then commit with matching tag
      cyc(0, 1, 3, 0, 1, 3, 7, 0, 0, 0, 0);
      cyc(0, 1, 3, 0, 0, 0, 0, 3, 7, 32'h1234, 0);
      cyc(0, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
      // older commit keeps younger rename tag
      cyc(0, 1, 4, 0, 1, 4, 2, 0, 0, 0, 0);
      cyc(0, 1, 4, 0, 1, 4, 5, 0, 0, 0, 0);
      cyc(0, 1, 4, 0, 0, 0, 0, 4, 2, 32'hAA, 0);
      cyc(0, 1, 4, 0, 0, 0, 0, 4, 5, 32'hBB, 0);
      cyc(0, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      // same-cycle rename and commit
      cyc(0, 1, 6, 0, 1, 6, 9, 6, 3, 32'h55, 0);
      cyc(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0);
      // misbranch with commit and rename
      cyc(0, 1, 1, 2, 1, 1, 1, 0, 0, 0, 0);
      cyc(0, 1, 1, 2, 1, 2, 2, 0, 0, 0, 0);
      cyc(0, 1, 1, 2, 1, 7, 4, 1, 1, 32'h80, 1);
      cyc(0, 1, 1, 7, 1, 2, 2, 0, 0, 0, 0);
      // rdy low holds everything
      cyc(0, 0, 1, 2, 1, 7, 4, 1, 2, 32'h81, 1);
      cyc(0, 1, 1, 2, 0, 0, 0, 0, 0, 0, 0);
      // x0 writes ignored
      cyc(0, 1, 0, 0, 1, 0, 3, 0, 0, 32'hFFFF, 0);
      cyc(0, 1, 0, 8, 1, 8, 6, 0, 0, 0, 0);
      // commit while reading the same register
      cyc(0, 1, 8, 0, 0, 0, 0, 8, 6, 32'h99, 0);
      cyc(0, 1, 8, 0, 0, 0, 0, 0, 0, 0, 0);
      // random traffic concentrated on a few registers
      for (int n = 0; n < 600; n++) begin
         ci = ($urandom_range(0, 9) < 4) ? REG_IDX_W'($urandom_range(0, 7)) : '0;
         ct = ($urandom_range(0, 1) == 1) ? m_tag[ci] : ROB_TAG_W'($urandom_range(1, 15));
         rd = REG_IDX_W'($urandom_range(0, 7));
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) != 0),
             REG_IDX_W'($urandom_range(0, 8)), REG_IDX_W'($urandom_range(0, 8)),
             ($urandom_range(0, 1) == 1), rd, ROB_TAG_W'($urandom_range(1, 15)),
             ci, ct, $urandom, ($urandom_range(0, 19) == 0));
      end
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if (q.size() != 0) begin
         n_fails++;
         $display("FAIL drain: %0d entries left, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

`default_nettype wire
